// File: rtl/loader_pkg.sv
// loader_pkg: shared widths and FSM states for the sample_loader slice
package loader_pkg;
    localparam int DATA_W   = 16;
    localparam int SECTOR_W = 4;
    localparam int ADDR_W   = 4;
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, RUN} loader_state_t;
endpackage

// File: rtl/loader_addr_gen.sv
// loader_addr_gen: frame word index counter mapped onto sector/address of the data memory
module loader_addr_gen
    import loader_pkg::*;
#(
    parameter int BASE_SECTOR = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                en,
    output logic [7:0]          idx,
    output logic [SECTOR_W-1:0] sector,
    output logic [ADDR_W-1:0]   addr
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) idx <= '0;
        else if (clr) idx <= '0;
        else if (en) idx <= idx + 8'd1;
    assign sector = SECTOR_W'(BASE_SECTOR) + idx[7:4];
    assign addr   = idx[3:0];
endmodule

// File: rtl/sample_loader.sv
// sample_loader: streams one sample frame into the core's sectored memory, then starts the core.
// Optional SAMPLE_LOADER_CHECKSUM_EN adds a 16-bit wrap-around checksum output.
module sample_loader
    import loader_pkg::*;
#(
    parameter int NUM_WORDS   = 16,
    parameter int BASE_SECTOR = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                go,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                wr_en,
    output logic [SECTOR_W-1:0] wr_sector,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                core_start,
    input  logic                core_done,
    output logic                busy,
    output logic                frame_err,
`ifdef SAMPLE_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0]   checksum,
`endif
    output logic [8:0]          words_loaded
);
    generate
        if (NUM_WORDS < 1 || BASE_SECTOR < 0 || BASE_SECTOR > 15 || NUM_WORDS > 256 - 16 * BASE_SECTOR) begin : g_bad_cfg
            $error("sample_loader: NUM_WORDS/BASE_SECTOR out of range");
        end
    endgenerate

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    loader_state_t       state, state_nx;
    logic                xfer, at_end, go_ok;
    logic [7:0]          idx;
    logic [SECTOR_W-1:0] sector;
    logic [ADDR_W-1:0]   addr;

    assign s_ready    = state == LOAD;
    assign busy       = state != IDLE;
    assign core_start = state == START;
    assign xfer       = s_valid && s_ready;
    assign at_end     = idx == LAST_IDX;
    assign go_ok      = state == IDLE && go;

    loader_addr_gen #(.BASE_SECTOR(BASE_SECTOR)) u_addr_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (go_ok),
        .en     (xfer),
        .idx    (idx),
        .sector (sector),
        .addr   (addr)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? LOAD : IDLE;
            LOAD:    state_nx = !xfer ? LOAD : at_end ? FLUSH : s_last ? IDLE : LOAD;
            FLUSH:   state_nx = START;
            START:   state_nx = RUN;
            RUN:     state_nx = core_done ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // s_last must coincide exactly with the final index; any mismatch is a framing error
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state        <= IDLE;
            wr_en        <= 1'b0;
            wr_sector    <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_err    <= 1'b0;
            words_loaded <= '0;
        end else begin
            state <= state_nx;
            wr_en <= xfer;
            if (go_ok) begin
                frame_err    <= 1'b0;
                words_loaded <= '0;
            end
            if (xfer) begin
                wr_sector    <= sector;
                wr_addr      <= addr;
                wr_data      <= s_data;
                words_loaded <= {1'b0, idx} + 9'd1;
                if (at_end ^ s_last) frame_err <= 1'b1;
            end
        end

`ifdef SAMPLE_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) checksum <= '0;
        else if (go_ok) checksum <= '0;
        else if (xfer) checksum <= checksum + s_data;
`endif
endmodule
